// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I MEM stage, drives a req/gnt/rvalid data bus and registers results into MEM/WB.
module mem_access_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] mem_alu_result,
    input  logic [DATA_WIDTH-1:0] mem_rs2_data,
    input  logic [4:0]            mem_rd_addr,
    input  logic [2:0]            mem_funct3,
    input  logic                  mem_MemRead,
    input  logic                  mem_MemWrite,
    input  logic                  mem_MemToReg,
    input  logic                  mem_RegWrite,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  mem_stall,
    output logic [DATA_WIDTH-1:0] wb_alu_result,
    output logic [DATA_WIDTH-1:0] wb_load_data,
    output logic [4:0]            wb_rd_addr,
    output logic                  wb_MemToReg,
    output logic                  wb_RegWrite,
    output logic                  wb_misaligned
);
    localparam logic [1:0] IDLE = 2'd0, WAIT_GNT = 2'd1, WAIT_RSP = 2'd2;

    logic [1:0]            state, state_nxt;
    logic [ADDR_WIDTH-1:0] l_addr;
    logic                  l_we, l_mtr, l_rw;
    logic [3:0]            l_be;
    logic [DATA_WIDTH-1:0] l_wdata, l_alu;
    logic [2:0]            l_funct3;
    logic [4:0]            l_rd;
    logic                  idle, access, misaligned, start;
    logic                  is_b, is_h;
    logic [1:0]            off;
    logic [3:0]            be_in;
    logic [DATA_WIDTH-1:0] wdata_in, load_ext;
    logic [7:0]            ld_b;
    logic [15:0]           ld_h;

    // Size comes from funct3[1:0]; every encoding other than B/H behaves as a word.
    assign off        = mem_alu_result[1:0];
    assign is_b       = mem_funct3[1:0] == 2'b00;
    assign is_h       = mem_funct3[1:0] == 2'b01;
    assign access     = mem_MemRead | mem_MemWrite;
    assign misaligned = access & (is_b ? 1'b0 : is_h ? off[0] : off != 2'b00);
    assign start      = access & ~misaligned;
    assign idle       = state == IDLE;

    assign be_in    = is_b ? 4'b0001 << off : is_h ? 4'b0011 << off : 4'b1111;
    assign wdata_in = is_b ? {4{mem_rs2_data[7:0]}} : is_h ? {2{mem_rs2_data[15:0]}} : mem_rs2_data;

    // In IDLE the bus follows the inputs directly; afterwards it is held from the latched copy.
    assign dmem_req   = ~rst & ((idle & start) | state == WAIT_GNT);
    assign dmem_we    = idle ? mem_MemWrite : l_we;
    assign dmem_addr  = idle ? {mem_alu_result[ADDR_WIDTH-1:2], 2'b00} : {l_addr[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_be    = idle ? be_in : l_be;
    assign dmem_wdata = idle ? wdata_in : l_wdata;

    assign mem_stall = idle ? start & ~(dmem_gnt & mem_MemWrite) :
                       state == WAIT_GNT ? ~(dmem_gnt & l_we) : ~dmem_rvalid;

    assign ld_b     = dmem_rdata[{l_addr[1:0], 3'b000} +: 8];
    assign ld_h     = dmem_rdata[{l_addr[1], 4'b0000} +: 16];
    assign load_ext = l_funct3[1:0] == 2'b00 ? {{24{~l_funct3[2] & ld_b[7]}}, ld_b} :
                      l_funct3[1:0] == 2'b01 ? {{16{~l_funct3[2] & ld_h[15]}}, ld_h} : dmem_rdata;

    always_comb begin
        state_nxt = IDLE;
        if (idle)
            state_nxt = !start ? IDLE : !dmem_gnt ? WAIT_GNT : mem_MemWrite ? IDLE : WAIT_RSP;
        else if (state == WAIT_GNT)
            state_nxt = !dmem_gnt ? WAIT_GNT : l_we ? IDLE : WAIT_RSP;
        else if (state == WAIT_RSP)
            state_nxt = dmem_rvalid ? IDLE : WAIT_RSP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            l_addr   <= '0;
            l_we     <= 1'b0;
            l_be     <= '0;
            l_wdata  <= '0;
            l_funct3 <= '0;
            l_rd     <= '0;
            l_mtr    <= 1'b0;
            l_rw     <= 1'b0;
            l_alu    <= '0;
        end else begin
            state <= state_nxt;
            if (idle & start) begin
                l_addr   <= mem_alu_result[ADDR_WIDTH-1:0];
                l_we     <= mem_MemWrite;
                l_be     <= be_in;
                l_wdata  <= wdata_in;
                l_funct3 <= mem_funct3;
                l_rd     <= mem_rd_addr;
                l_mtr    <= mem_MemToReg;
                l_rw     <= mem_RegWrite;
                l_alu    <= mem_alu_result;
            end
        end
    end

    // A stalled cycle writes a bubble so WB sees each instruction exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || mem_stall) begin
            wb_alu_result <= '0;
            wb_load_data  <= '0;
            wb_rd_addr    <= '0;
            wb_MemToReg   <= 1'b0;
            wb_RegWrite   <= 1'b0;
            wb_misaligned <= 1'b0;
        end else begin
            wb_alu_result <= idle ? mem_alu_result : l_alu;
            wb_load_data  <= state == WAIT_RSP ? load_ext : '0;
            wb_rd_addr    <= idle ? mem_rd_addr : l_rd;
            wb_MemToReg   <= idle ? mem_MemToReg : l_mtr;
            wb_RegWrite   <= idle ? mem_RegWrite & ~misaligned : l_rw;
            wb_misaligned <= idle & misaligned;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed table plus randomized accesses checked against a latency/encoding model.
module tb_mem_access_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] mem_alu_result = '0, mem_rs2_data = '0, dmem_rdata = '0;
    logic [4:0]  mem_rd_addr = '0;
    logic [2:0]  mem_funct3 = '0;
    logic        mem_MemRead = 1'b0, mem_MemWrite = 1'b0, mem_MemToReg = 1'b0, mem_RegWrite = 1'b0;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic        dmem_req, dmem_we, mem_stall;
    logic [31:0] dmem_addr, dmem_wdata, wb_alu_result, wb_load_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd_addr;
    logic        wb_MemToReg, wb_RegWrite, wb_misaligned;
    int          checks = 0, errors = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data), .mem_rd_addr(mem_rd_addr),
        .mem_funct3(mem_funct3), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_MemToReg(mem_MemToReg), .mem_RegWrite(mem_RegWrite),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
        .wb_rd_addr(wb_rd_addr), .wb_MemToReg(wb_MemToReg), .wb_RegWrite(wb_RegWrite),
        .wb_misaligned(wb_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic        rd_en, wr_en;
        logic [31:0] addr, rs2, rdata;
        logic [4:0]  rd;
        logic        mtr, rw;
        int          g, r;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
    } vec_t;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic is_mis(input logic [2:0] f, input logic [31:0] a);
        case (f)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            default:        return a[1:0] != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
        case (f)
            3'b000:  return 4'b0001 << a[1:0];
            3'b001:  return 4'b0011 << a[1:0];
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
        case (f)
            3'b000:  return {4{d[7:0]}};
            3'b001:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        logic [7:0]  b = 8'(d >> (8 * a[1:0]));
        logic [15:0] h = 16'(d >> (16 * a[1]));
        case (f)
            3'b000:  return 32'($signed(b));
            3'b100:  return {24'b0, b};
            3'b001:  return 32'($signed(h));
            3'b101:  return {16'b0, h};
            default: return d;
        endcase
    endfunction

    // Called just after a posedge; returns just after the posedge that registers the result.
    task automatic do_access(input vec_t v);
        logic acc = v.rd_en | v.wr_en;
        logic mis = acc & is_mis(v.f3, v.addr);
        logic ok  = acc & ~mis;
        int   n   = !ok ? 0 : v.wr_en ? v.g : v.g + v.r;
        mem_funct3 = v.f3; mem_MemRead = v.rd_en; mem_MemWrite = v.wr_en;
        mem_alu_result = v.addr; mem_rs2_data = v.rs2; mem_rd_addr = v.rd;
        mem_MemToReg = v.mtr; mem_RegWrite = v.rw; dmem_rdata = v.rdata;
        for (int c = 0; c <= n; c++) begin
            dmem_gnt    = ok && c == v.g;
            dmem_rvalid = (ok && !v.wr_en && c == v.g + v.r) || (c <= v.g && $urandom_range(0, 1) == 1);
            if (!ok || v.wr_en) dmem_rvalid = !ok ? 1'b0 : dmem_rvalid && c <= v.g;
            @(negedge clk);
            chk("req", dmem_req, ok && c <= v.g);
            chk("stall", mem_stall, c < n);
            if (ok && c <= v.g) begin
                chk("addr", dmem_addr, {v.addr[31:2], 2'b00});
                chk("we", dmem_we, v.wr_en);
                if (v.wr_en) chk("be", dmem_be, v.exp_be);
                if (v.wr_en) chk("wdata", dmem_wdata, v.exp_data);
            end
            if (c > 0)
                chk("wb_bubble", {wb_alu_result, wb_load_data, wb_rd_addr, wb_MemToReg, wb_RegWrite, wb_misaligned}, '0);
            @(posedge clk); #1;
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk("wb_misaligned", wb_misaligned, mis);
        chk("wb_RegWrite", wb_RegWrite, v.rw & ~mis);
        if (!mis) begin
            chk("wb_alu_result", wb_alu_result, v.addr);
            chk("wb_rd_addr", wb_rd_addr, v.rd);
            chk("wb_MemToReg", wb_MemToReg, v.mtr);
        end
        if (ok && !v.wr_en) chk("wb_load_data", wb_load_data, v.exp_data);
    endtask

    task automatic bubble();
        mem_MemRead = 1'b0; mem_MemWrite = 1'b0; mem_RegWrite = 1'b0; mem_MemToReg = 1'b0;
        mem_alu_result = '0; mem_rd_addr = '0;
    endtask

    initial begin
        vec_t tbl[12];
        vec_t v;
        //          f3      rd wr addr          rs2           rdata         rd  mtr rw g r exp_data      be
        tbl[0]  = '{3'b000, 1, 0, 32'h1003,     32'h0,        32'h80FF1234, 5,  1, 1, 0, 1, 32'hFFFFFF80, 4'b0};
        tbl[1]  = '{3'b001, 0, 1, 32'h2002,     32'h0000BEEF, 32'h0,        0,  0, 0, 3, 1, 32'hBEEFBEEF, 4'b1100};
        tbl[2]  = '{3'b010, 1, 0, 32'h3001,     32'h0,        32'h0,        9,  1, 1, 0, 1, 32'h0,        4'b0};
        tbl[3]  = '{3'b000, 0, 0, 32'h55,       32'h0,        32'h0,        7,  0, 1, 0, 1, 32'h0,        4'b0};
        tbl[4]  = '{3'b100, 1, 0, 32'h1001,     32'h0,        32'h12345678, 4,  1, 1, 2, 2, 32'h00000056, 4'b0};
        tbl[5]  = '{3'b001, 1, 0, 32'h0002,     32'h0,        32'h80010000, 6,  1, 1, 0, 3, 32'hFFFF8001, 4'b0};
        tbl[6]  = '{3'b101, 1, 0, 32'h0002,     32'h0,        32'h80010000, 6,  1, 1, 1, 1, 32'h00008001, 4'b0};
        tbl[7]  = '{3'b000, 0, 1, 32'h0011,     32'h000000AB, 32'h0,        0,  0, 0, 0, 1, 32'hABABABAB, 4'b0010};
        tbl[8]  = '{3'b010, 0, 1, 32'h0020,     32'hDEADBEEF, 32'h0,        0,  0, 0, 1, 1, 32'hDEADBEEF, 4'b1111};
        tbl[9]  = '{3'b010, 1, 0, 32'h0040,     32'h0,        32'hCAFEF00D, 0,  1, 1, 1, 1, 32'hCAFEF00D, 4'b0};
        tbl[10] = '{3'b011, 1, 0, 32'h0044,     32'h0,        32'h12345678, 3,  1, 1, 0, 2, 32'h12345678, 4'b0};
        tbl[11] = '{3'b001, 0, 1, 32'h0005,     32'h1234,     32'h0,        0,  0, 0, 0, 1, 32'h0,        4'b0};

        #2;
        chk("reset_req", dmem_req, 1'b0);
        chk("reset_wb", {wb_alu_result, wb_load_data, wb_rd_addr, wb_MemToReg, wb_RegWrite, wb_misaligned}, '0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) do_access(tbl[i]);

        for (int k = 0; k < 200; k++) begin
            int kind = $urandom_range(0, 3);
            v.rd_en = kind == 1; v.wr_en = kind >= 2;
            v.f3    = v.wr_en ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            v.addr  = $urandom; v.rs2 = $urandom; v.rdata = $urandom;
            v.rd    = 5'($urandom); v.mtr = 1'($urandom); v.rw = 1'($urandom);
            v.g     = $urandom_range(0, 3); v.r = $urandom_range(1, 3);
            v.exp_be   = m_be(v.f3, v.addr);
            v.exp_data = v.wr_en ? m_wdata(v.f3, v.rs2) : m_load(v.f3, v.addr, v.rdata);
            do_access(v);
        end

        // Reset while a granted LHU waits for its response; the late rvalid must be ignored.
        mem_funct3 = 3'b101; mem_MemRead = 1'b1; mem_MemWrite = 1'b0; mem_alu_result = 32'h4002;
        mem_rd_addr = 5'd3; mem_RegWrite = 1'b1; mem_MemToReg = 1'b1; dmem_gnt = 1'b1;
        @(negedge clk);
        chk("rst_seq_req", dmem_req, 1'b1);
        @(posedge clk); #1; dmem_gnt = 1'b0;
        @(negedge clk);
        chk("rst_seq_wait", mem_stall, 1'b1);
        #1 rst = 1'b1; #1;
        chk("rst_seq_req_now", dmem_req, 1'b0);
        chk("rst_seq_wb", {wb_alu_result, wb_load_data, wb_rd_addr, wb_MemToReg, wb_RegWrite, wb_misaligned}, '0);
        @(posedge clk); #1; bubble();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF1111;
        @(negedge clk);
        chk("late_rvalid_stall", mem_stall, 1'b0);
        chk("late_rvalid_req", dmem_req, 1'b0);
        @(posedge clk); #1; dmem_rvalid = 1'b0;
        chk("late_rvalid_wb", {wb_alu_result, wb_load_data, wb_rd_addr, wb_MemToReg, wb_RegWrite, wb_misaligned}, '0);
        v = '{3'b010, 1, 0, 32'h5000, 32'h0, 32'h01020304, 8, 1, 1, 0, 1, 32'h01020304, 4'b0};
        do_access(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
